// File: rtl/sequenciador_jogadas_uc.sv
// Moore control unit sequencing player moves against the memory-compare datapath.
// Optional ESPERA timeout (counter and FIM_TIMEOUT) is enabled by defining UC_TIMEOUT_EN.
module sequenciador_jogadas_uc #(
  parameter int unsigned TIMEOUT_CYCLES = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARACAO  = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_ERRO    = 4'hE;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;

  logic [3:0] state, state_next;
  logic       expirou;

`ifdef UC_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;

  // Counts consecutive ESPERA cycles; cleared elsewhere, held at terminal count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state != ESPERA) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT_CYCLES - 1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expirou = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= state_next;
  end

  // Next-state logic; a move in ESPERA takes priority over expiry.
  always_comb begin
    state_next = INICIAL;
    case (state)
      INICIAL:    state_next = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: state_next = ESPERA;
      ESPERA: begin
        if (jogada)       state_next = REGISTRA;
        else if (expirou) state_next = FIM_TIMEOUT;
        else              state_next = ESPERA;
      end
      REGISTRA:   state_next = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    state_next = FIM_ERRO;
        else if (fimC) state_next = FIM_ACERTO;
        else           state_next = PROXIMO;
      end
      PROXIMO:    state_next = ESPERA;
      FIM_ACERTO: state_next = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:   state_next = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: state_next = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:    state_next = INICIAL;
    endcase
  end

  // Moore output decode
  always_comb begin
    zeraC     = 1'b0;
    zeraR     = 1'b0;
    contaC    = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = 4'hF;
    case (state)
      INICIAL, PREPARACAO: begin
        zeraC     = 1'b1;
        zeraR     = 1'b1;
        db_estado = state;
      end
      ESPERA:     db_estado = state;
      REGISTRA: begin
        registraR = 1'b1;
        db_estado = state;
      end
      COMPARACAO: db_estado = state;
      PROXIMO: begin
        contaC    = 1'b1;
        db_estado = state;
      end
      FIM_ACERTO: begin
        pronto    = 1'b1;
        acertou   = 1'b1;
        db_estado = state;
      end
      FIM_ERRO: begin
        pronto    = 1'b1;
        errou     = 1'b1;
        db_estado = state;
      end
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto    = 1'b1;
        timeout   = 1'b1;
        db_estado = state;
      end
`endif
      default: db_estado = 4'hF;
    endcase
  end

endmodule

// File: doc/sequenciador_jogadas_uc.md
Name: sequenciador_jogadas_uc

Overview:
Moore control unit for the memory-compare datapath (address counter, play register, comparator, memory).
- Waits for each player move, registers it, compares it with the stored value and steps the counter.
- Ends in hit, miss or timeout.
- Sits beside the datapath in the game top level.
- Drives the datapath's zera/conta/registra controls and reports the result to the top-level FSM and LEDs.

Parameters:
TIMEOUT_CYCLES, 3000, cycles allowed in ESPERA before declaring timeout (≥2).

Ports:
clock      input   1  system clock, rising edge
reset      input   1  asynchronous, active-high; forces INICIAL
iniciar    input   1  start/restart request, sampled in INICIAL and in the FIM_* states
jogada     input   1  one-cycle pulse from the datapath edge detector: a button was pressed
igual      input   1  comparator: registered play equals memory data
fimC       input   1  address counter at last position
zeraC      output  1  clear address counter
contaC     output  1  increment address counter
zeraR      output  1  clear play register
registraR  output  1  load play register
pronto     output  1  game finished (any FIM_* state)
acertou    output  1  finished, all plays correct
errou      output  1  finished, wrong play
timeout    output  1  finished, no play within TIMEOUT_CYCLES
db_estado  output  4  debug state code

Behaviour:
- Reset: reset is asynchronous, active-high; the clock is clock. Reset immediately sets the state to INICIAL and the timeout counter to 0.
  - Outputs at reset: zeraC=1, zeraR=1, all other 1-bit outputs 0, db_estado=0x0.
- States and db_estado codes: INICIAL 0x0, PREPARACAO 0x1, ESPERA 0x2, REGISTRA 0x4, COMPARACAO 0x5, PROXIMO 0x6, FIM_ACERTO 0xA, FIM_ERRO 0xE, FIM_TIMEOUT 0xD. Any unused encoding shows db_estado 0xF and goes to INICIAL on the next clock.
- Transitions, evaluated at each clock edge:
  - INICIAL: iniciar -> PREPARACAO, else stay.
  - PREPARACAO -> ESPERA, unconditional.
  - ESPERA, by priority:
    1. jogada -> REGISTRA.
    2. Timeout counter == TIMEOUT_CYCLES-1 -> FIM_TIMEOUT.
    3. Otherwise stay.
  - REGISTRA -> COMPARACAO, unconditional. igual is valid from COMPARACAO onward.
  - COMPARACAO, by priority:
    1. !igual -> FIM_ERRO.
    2. igual & fimC -> FIM_ACERTO.
    3. igual & !fimC -> PROXIMO.
  - PROXIMO -> ESPERA.
  - FIM_*: iniciar -> PREPARACAO (new game, counter and register cleared), else hold.
- Moore outputs, all purely decoded from the state:
  - zeraC = zeraR = 1 in INICIAL and PREPARACAO.
  - registraR = 1 in REGISTRA.
  - contaC = 1 in PROXIMO.
  - pronto = 1 in all FIM_* states.
  - acertou = 1 in FIM_ACERTO; errou = 1 in FIM_ERRO; timeout = 1 in FIM_TIMEOUT.
  - acertou, errou and timeout are mutually exclusive.
- Timeout counter:
  - Width ceil(log2(TIMEOUT_CYCLES)), unsigned.
  - Increments each clock while in ESPERA.
  - Synchronously cleared in every other state, so each ESPERA visit starts from 0.
  - Saturates and never wraps.
  - Timeout is declared after exactly TIMEOUT_CYCLES consecutive ESPERA cycles without jogada.
- Boundaries:
  - jogada in the same cycle as terminal count: the play wins (REGISTRA).
  - jogada outside ESPERA is ignored.
  - iniciar outside INICIAL/FIM_* is ignored.
  - Reset at any point, including mid-compare, aborts to INICIAL the same cycle.
- Latency per correct non-final play: jogada edge -> REGISTRA -> COMPARACAO -> PROXIMO -> ESPERA, i.e. 3 cycles out of ESPERA.

Optional Feature:
Macro UC_TIMEOUT_EN.
- Defined: timeout counter and FIM_TIMEOUT exist as described above.
- Undefined:
  - Counter logic is removed.
  - ESPERA leaves only on jogada.
  - timeout output is tied 0.
  - db_estado never shows 0xD.
  - TIMEOUT_CYCLES is unused.

Test Plan:
All scenarios use TIMEOUT_CYCLES=10.
1. Reset, then iniciar pulse -> db 0x0→0x1→0x2; zeraC/zeraR high in 0x0/0x1 only.
2. Correct game of 4 (igual=1; fimC=1 on the 4th COMPARACAO) -> contaC pulses 3 times, registraR 4 times; ends in 0xA with pronto=1, acertou=1, held until iniciar.
3. igual=0 on the 2nd play -> COMPARACAO→FIM_ERRO; db=0xE, errou=1, pronto=1, contaC pulsed once.
4. No jogada for 10 cycles in ESPERA -> db=0xD, timeout=1 on the 11th cycle. Also jogada on the 10th cycle -> REGISTRA, no timeout. Also a second ESPERA visit restarts the count at 0.
5. Assert reset while in COMPARACAO, then iniciar from FIM_ERRO -> immediate db=0x0, all outputs at reset values; next game proceeds via PREPARACAO with counter cleared.
6. Compile without UC_TIMEOUT_EN, idle 50 cycles in ESPERA -> stays in 0x2, timeout=0.
